mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 51 +++++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared FSM state encoding and requester owner codes for the
//               instruction-fetch / load-store memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_D_WAIT  = 2'd2
    } arb_state_e;

    // Owner codes returned by the selection logic
    localparam logic OWN_D  = 1'b0;
    localparam logic OWN_IF = 1'b1;

endpackage : mem_arbiter_pkg

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational owner selection between fetch and data ports.
//               Default build: data wins unless fetch has been starved for
//               STARVE_MAX consecutive data grants.
//               MEM_ARB_RR_EN defined: round-robin, last owner loses ties.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req_i,
    input  logic             d_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic             last_own_i,
`else
    input  logic [CNT_W-1:0] starve_cnt_i,
`endif
    output logic             own_o
);

`ifdef MEM_ARB_RR_EN
    // Round-robin: on a tie the port that did not win last time is chosen
    always_comb begin
        own_o = OWN_D;
        if (if_req_i && d_req_i) begin
            own_o = (last_own_i == OWN_D) ? OWN_IF : OWN_D;
        end else if (if_req_i) begin
            own_o = OWN_IF;
        end
    end
`else
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

    // Fixed data priority with a starvation escape for fetch
    always_comb begin
        own_o = OWN_D;
        if (if_req_i && (!d_req_i || (starve_cnt_i == C_STARVE_MAX))) begin
            own_o = OWN_IF;
        end
    end
`endif

endmodule : mem_arb_pick

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a single-port memory between instruction fetch and
//               load/store. One outstanding command at a time; responses are
//               routed combinationally to the owning requester.
//               Optional macro MEM_ARB_RR_EN selects round-robin arbitration
//               (starvation counter removed).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // Instruction fetch port
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_rvalid_o,
    output logic [31:0]         if_rdata_o,
    // Load/store port
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    // Shared memory command / response
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    // Pipeline stall requests
    output logic                stall_if_o,
    output logic                stall_mem_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e state_q;
    logic       if_bit_q;      // if_addr_i[2] of the fetch in flight
    logic       own_d;         // owner picked for this IDLE cycle
    logic       grant_d;       // command accepted this cycle

    // Requests issue only from IDLE; outputs are forced low while in reset
    assign mem_req_o = rst_ni && (state_q == ST_IDLE) && (if_req_i || d_req_i);
    assign grant_d   = mem_req_o && mem_gnt_i;

`ifdef MEM_ARB_RR_EN
    logic last_own_q;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .if_req_i   (if_req_i),
        .d_req_i    (d_req_i),
        .last_own_i (last_own_q),
        .own_o      (own_d)
    );

    // Remember the most recent winner; reset value lets data win the first tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_own_q <= OWN_IF;
        end else if (grant_d) begin
            last_own_q <= own_d;
        end
    end
`else
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;

    mem_arb_pick #(
        .STARVE_MAX   (STARVE_MAX),
        .CNT_W        (CNT_W)
    ) u_pick (
        .if_req_i     (if_req_i),
        .d_req_i      (d_req_i),
        .starve_cnt_i (starve_cnt_q),
        .own_o        (own_d)
    );

    // Count data grants that overtake a waiting fetch, saturating at the limit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else if (!if_req_i) begin
            starve_cnt_q <= '0;
        end else if (grant_d) begin
            if (own_d == OWN_IF) begin
                starve_cnt_q <= '0;
            end else if (starve_cnt_q != C_STARVE_MAX) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
        end
    end
`endif

    // Command mux: fetch reads never write; fields are zero when idle
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (mem_req_o) begin
            if (own_d == OWN_IF) begin
                mem_addr_o  = if_addr_i;
            end else begin
                mem_we_o    = d_we_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
                mem_wstrb_o = d_wstrb_i;
            end
        end
    end

    // Responses only reach a requester that is still asking; late or
    // abandoned responses are dropped without a pulse
    assign if_rvalid_o = rst_ni && (state_q == ST_IF_WAIT) && mem_rvalid_i && if_req_i;
    assign d_rvalid_o  = rst_ni && (state_q == ST_D_WAIT)  && mem_rvalid_i && d_req_i;
    assign if_rdata_o  = !rst_ni ? 32'd0 : (if_bit_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0]);
    assign d_rdata_o   = rst_ni ? mem_rdata_i : '0;

    assign stall_if_o  = rst_ni && if_req_i && !if_rvalid_o;
    assign stall_mem_o = rst_ni && d_req_i && !d_rvalid_o;

    // Transaction FSM: grant moves to the owner's wait state, response returns to IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            if_bit_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        if (own_d == OWN_IF) begin
                            state_q  <= ST_IF_WAIT;
                            if_bit_q <= if_addr_i[2];
                        end else begin
                            state_q  <= ST_D_WAIT;
                        end
                    end
                end
                ST_IF_WAIT, ST_D_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Cycle-by-cycle vector bench for mem_arbiter. Each record gives
//               the inputs for one cycle and the outputs expected before the
//               following rising edge. Builds with or without MEM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    typedef struct {
        logic        rst_n;
        logic        if_req;
        logic [63:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [7:0]  d_wstrb;
        logic        gnt;
        logic        rvalid;
        logic [63:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_wstrb;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_dv;
        logic        e_sif;
        logic        e_smem;
    } vec_t;

    localparam logic [63:0] A1  = 64'h0000_0000_8000_0004;
    localparam logic [63:0] A0  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DA  = 64'h0000_0000_0000_0100;
    localparam logic [63:0] DA2 = 64'h0000_0000_0000_0200;
    localparam logic [63:0] RD  = 64'h1111_2222_3333_4444;

    logic        clk;
    logic        rst_n;
    logic        if_req, d_req, d_we, gnt, rvalid;
    logic [63:0] if_addr, d_addr, d_wdata, rdata;
    logic [7:0]  d_wstrb;
    logic        if_rvalid, d_rvalid, mem_req, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata;
    logic [63:0] d_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    mem_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .d_req_i      (d_req),
        .d_we_i       (d_we),
        .d_addr_i     (d_addr),
        .d_wdata_i    (d_wdata),
        .d_wstrb_i    (d_wstrb),
        .d_rvalid_o   (d_rvalid),
        .d_rdata_o    (d_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wstrb_o  (mem_wstrb),
        .mem_gnt_i    (gnt),
        .mem_rvalid_i (rvalid),
        .mem_rdata_i  (rdata),
        .stall_if_o   (stall_if),
        .stall_mem_o  (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rs, input logic ir, input logic [63:0] ia,
        input logic dr, input logic dw, input logic [63:0] da,
        input logic [63:0] dwd, input logic [7:0] dws,
        input logic g, input logic rv, input logic [63:0] rd,
        input logic er, input logic ew, input logic [63:0] ea,
        input logic [63:0] ewd, input logic [7:0] ews,
        input logic eiv, input logic [31:0] eid, input logic edv,
        input logic esi, input logic esm);
        vec_t v;
        v.rst_n = rs;  v.if_req = ir; v.if_addr = ia;
        v.d_req = dr;  v.d_we = dw;   v.d_addr = da;
        v.d_wdata = dwd; v.d_wstrb = dws;
        v.gnt = g;     v.rvalid = rv; v.rdata = rd;
        v.e_req = er;  v.e_we = ew;   v.e_addr = ea;
        v.e_wdata = ewd; v.e_wstrb = ews;
        v.e_ifv = eiv; v.e_ifd = eid; v.e_dv = edv;
        v.e_sif = esi; v.e_smem = esm;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge, check mid-cycle, step
    task automatic apply(input vec_t v, input int idx);
        rst_n   = v.rst_n;  if_req = v.if_req; if_addr = v.if_addr;
        d_req   = v.d_req;  d_we   = v.d_we;   d_addr  = v.d_addr;
        d_wdata = v.d_wdata; d_wstrb = v.d_wstrb;
        gnt     = v.gnt;    rvalid = v.rvalid; rdata   = v.rdata;
        #3;
        chk("mem_req",   idx, 64'(mem_req),   64'(v.e_req));
        chk("mem_we",    idx, 64'(mem_we),    64'(v.e_we));
        chk("mem_addr",  idx, mem_addr,       v.e_addr);
        chk("mem_wdata", idx, mem_wdata,      v.e_wdata);
        chk("mem_wstrb", idx, 64'(mem_wstrb), 64'(v.e_wstrb));
        chk("if_rvalid", idx, 64'(if_rvalid), 64'(v.e_ifv));
        chk("d_rvalid",  idx, 64'(d_rvalid),  64'(v.e_dv));
        chk("stall_if",  idx, 64'(stall_if),  64'(v.e_sif));
        chk("stall_mem", idx, 64'(stall_mem), 64'(v.e_smem));
        if (v.e_ifv) chk("if_rdata", idx, 64'(if_rdata), 64'(v.e_ifd));
        if (v.e_dv)  chk("d_rdata",  idx, d_rdata, v.rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; rdata = '0;
        @(posedge clk);
        #1;

        //             rs ir ia  dr dw da   dwd           dws    g  rv rd              er ew ea   ewd           ews    iv id            dv si sm
        // Reset holds every output low even with both requests up
        vecs.push_back(mk(0, 1, A1, 1, 0, DA,  64'h0,        8'h00, 1, 0, 64'h0,          0, 0, 64'h0, 64'h0,     8'h00, 0, 32'h0,        0, 0, 0));
        // Spurious response in IDLE is ignored
        vecs.push_back(mk(1, 0, A1, 0, 0, DA,  64'h0,        8'h00, 0, 1, RD,             0, 0, 64'h0, 64'h0,     8'h00, 0, 32'h0,        0, 0, 0));
        // Simultaneous: data first, fetch stalls
        vecs.push_back(mk(1, 1, A1, 1, 0, DA,  64'h55,       8'h00, 1, 0, 64'h0,          1, 0, DA,    64'h55,    8'h00, 0, 32'h0,        0, 1, 1));
        vecs.push_back(mk(1, 1, A1, 1, 0, DA,  64'h55,       8'h00, 0, 1, 64'hAAAABBBBCCCCDDDD, 0, 0, 64'h0, 64'h0, 8'h00, 0, 32'h0,       1, 1, 0));
        // Fetch on the following IDLE; grant arrives one cycle late
        vecs.push_back(mk(1, 1, A1, 0, 0, DA,  64'h0,        8'h00, 0, 0, 64'h0,          1, 0, A1,    64'h0,     8'h00, 0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(1, 1, A1, 0, 0, DA,  64'h0,        8'h00, 1, 0, 64'h0,          1, 0, A1,    64'h0,     8'h00, 0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(1, 1, A1, 0, 0, DA,  64'h0,        8'h00, 0, 1, RD,             0, 0, 64'h0, 64'h0,     8'h00, 1, 32'h11112222, 0, 0, 0));
        vecs.push_back(mk(1, 0, A1, 0, 0, DA,  64'h0,        8'h00, 0, 0, 64'h0,          0, 0, 64'h0, 64'h0,     8'h00, 0, 32'h0,        0, 0, 0));
        // Fetch with addr bit 2 clear takes the low word
        vecs.push_back(mk(1, 1, A0, 0, 0, DA,  64'h0,        8'h00, 1, 0, 64'h0,          1, 0, A0,    64'h0,     8'h00, 0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(1, 1, A0, 0, 0, DA,  64'h0,        8'h00, 0, 1, RD,             0, 0, 64'h0, 64'h0,     8'h00, 1, 32'h33334444, 0, 0, 0));
        // Store: write fields pass through, ack pulses d_rvalid
        vecs.push_back(mk(1, 0, A0, 1, 1, DA2, 64'hDEADBEEF, 8'h0F, 1, 0, 64'h0,          1, 1, DA2,   64'hDEADBEEF, 8'h0F, 0, 32'h0,     0, 0, 1));
        vecs.push_back(mk(1, 0, A0, 1, 1, DA2, 64'hDEADBEEF, 8'h0F, 0, 1, 64'h0,          0, 0, 64'h0, 64'h0,     8'h00, 0, 32'h0,        1, 0, 0));
        // Fetch dropped mid-transaction: response swallowed, then back in IDLE
        vecs.push_back(mk(1, 1, A1, 0, 0, DA,  64'h0,        8'h00, 1, 0, 64'h0,          1, 0, A1,    64'h0,     8'h00, 0, 32'h0,        0, 1, 0));
        vecs.push_back(mk(1, 0, A1, 0, 0, DA,  64'h0,        8'h00, 0, 1, RD,             0, 0, 64'h0, 64'h0,     8'h00, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, A1, 1, 0, DA,  64'h0,        8'h00, 0, 0, 64'h0,          1, 0, DA,    64'h0,     8'h00, 0, 32'h0,        0, 0, 1));
        // Reset during D_WAIT, late response two cycles after release
        vecs.push_back(mk(1, 0, A1, 1, 0, DA,  64'h0,        8'h00, 1, 0, 64'h0,          1, 0, DA,    64'h0,     8'h00, 0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 0, A1, 1, 0, DA,  64'h0,        8'h00, 0, 0, 64'h0,          0, 0, 64'h0, 64'h0,     8'h00, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, A1, 1, 0, DA,  64'h0,        8'h00, 0, 0, 64'h0,          1, 0, DA,    64'h0,     8'h00, 0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(1, 0, A1, 1, 0, DA,  64'h0,        8'h00, 0, 1, 64'h99,         1, 0, DA,    64'h0,     8'h00, 0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(1, 0, A1, 0, 0, DA,  64'h0,        8'h00, 0, 0, 64'h0,          0, 0, 64'h0, 64'h0,     8'h00, 0, 32'h0,        0, 0, 0));

        n = 0;
        foreach (vecs[i]) begin
            apply(vecs[i], n);
            n++;
        end

        // Both ports requesting continuously, starting from a fresh reset
        apply(mk(0, 0, A1, 0, 0, DA, 64'h0, 8'h00, 0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00, 0, 32'h0, 0, 0, 0), n++);
`ifdef MEM_ARB_RR_EN
        // Round-robin: D, IF, D, IF
        for (int k = 0; k < 2; k++) begin
            apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 1, 0, 64'h0, 1, 0, DA, 64'h0, 8'h00, 0, 32'h0, 0, 1, 1), n++);
            apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 0, 1, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00, 0, 32'h0, 1, 1, 0), n++);
            apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 1, 0, 64'h0, 1, 0, A1, 64'h0, 8'h00, 0, 32'h0, 0, 1, 1), n++);
            apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 0, 1, RD, 0, 0, 64'h0, 64'h0, 8'h00, 1, 32'h11112222, 0, 0, 1), n++);
        end
`else
        // Fixed priority: exactly four data grants, then fetch, then data again
        for (int k = 0; k < 4; k++) begin
            apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 1, 0, 64'h0, 1, 0, DA, 64'h0, 8'h00, 0, 32'h0, 0, 1, 1), n++);
            apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 0, 1, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00, 0, 32'h0, 1, 1, 0), n++);
        end
        apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 1, 0, 64'h0, 1, 0, A1, 64'h0, 8'h00, 0, 32'h0, 0, 1, 1), n++);
        apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 0, 1, RD, 0, 0, 64'h0, 64'h0, 8'h00, 1, 32'h11112222, 0, 0, 1), n++);
        apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 1, 0, 64'h0, 1, 0, DA, 64'h0, 8'h00, 0, 32'h0, 0, 1, 1), n++);
        apply(mk(1, 1, A1, 1, 0, DA, 64'h0, 8'h00, 0, 1, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00, 0, 32'h0, 1, 1, 0), n++);
`endif
        apply(mk(1, 0, A1, 0, 0, DA, 64'h0, 8'h00, 0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h00, 0, 32'h0, 0, 0, 0), n++);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire
